// File: rtl/booth_multiplier_if.sv
// Bus between the control unit and the sequential Booth multiplier.
//
// Handshake: the master raises start for one clock edge with both operands
// valid on that same edge; the slave captures them, raises busy and ignores
// the operand lines until it finishes. On completion the slave drops busy and
// raises done for exactly one cycle; Hi/Lo are valid from that edge and hold
// until the next start or reset. A new start is accepted at any time and
// abandons the operation in flight without a done pulse.
interface booth_multiplier_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] multiplicando;
   logic [WIDTH-1:0] multiplicador;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] Hi;
   logic [WIDTH-1:0] Lo;
   logic             state_dbg;   // 1 while the FSM is in RUN

   modport master (
      output start, multiplicando, multiplicador,
      input  busy, done, Hi, Lo, state_dbg
   );

   modport slave (
      input  start, multiplicando, multiplicador,
      output busy, done, Hi, Lo, state_dbg
   );
endinterface

// File: rtl/booth_multiplier.sv
// Sequential signed WIDTH x WIDTH -> 2*WIDTH multiplier, radix-2 Booth.
// One add/subtract plus arithmetic shift per cycle; the result lands in
// Hi/Lo WIDTH edges after the start edge, with a one-cycle done pulse.
module booth_multiplier #(
   parameter int WIDTH = 32
) (
   input logic                clk,
   input logic                reset,
   booth_multiplier_if.slave  bus
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t state, state_next;

   // Accumulator and multiplicand carry one extra bit so that
   // M = -2^(WIDTH-1) can be negated without overflow.
   logic [WIDTH:0]   a_reg;
   logic [WIDTH:0]   mx;
   logic [WIDTH-1:0] q_reg;
   logic             q_1;
   logic [CW-1:0]    counter;

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   a_shift;
   logic [WIDTH-1:0] q_shift;
   logic             last;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next state: start always wins; RUN falls back to IDLE on the final iteration
   always_comb begin
      state_next = state;
      if (bus.start)
         state_next = RUN;
      else if (last)
         state_next = IDLE;
   end

   // Booth step: add/subtract by the recoded pair, then arithmetic shift of {A,Q,Q_1}
   always_comb begin
      sum = a_reg;
      case ({q_reg[0], q_1})
         2'b01:   sum = a_reg + mx;
         2'b10:   sum = a_reg - mx;
         default: sum = a_reg;
      endcase
      a_shift = {sum[WIDTH], sum[WIDTH:1]};
      q_shift = {sum[0], q_reg[WIDTH-1:1]};
      last    = (state == RUN) && (counter == CW'(1));
   end

   assign bus.state_dbg = (state == RUN);

   // Datapath and result registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_reg    <= '0;
         mx       <= '0;
         q_reg    <= '0;
         q_1      <= 1'b0;
         counter  <= '0;
         bus.Hi   <= '0;
         bus.Lo   <= '0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
      end else if (bus.start) begin
         a_reg    <= '0;
         mx       <= {bus.multiplicando[WIDTH-1], bus.multiplicando};
         q_reg    <= bus.multiplicador;
         q_1      <= 1'b0;
         counter  <= CW'(WIDTH);
         bus.Hi   <= '0;
         bus.Lo   <= '0;
         bus.busy <= 1'b1;
         bus.done <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         if (state == RUN) begin
            a_reg   <= a_shift;
            q_reg   <= q_shift;
            q_1     <= q_reg[0];
            counter <= counter - CW'(1);
            if (last) begin
               bus.Hi   <= a_shift[WIDTH-1:0];
               bus.Lo   <= q_shift;
               bus.busy <= 1'b0;
               bus.done <= 1'b1;
            end
         end
      end
   end

endmodule
